// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch sequencing controller. Holds the MM:SS BCD
//               counters and the PAUSED/RUN/ADJUST state machine, and scans
//               the four digits onto a shared active-low anode/segment bus,
//               blanking the selected field in adjust mode on the blink phase.
// Ports       : clk        - master clock, posedge
//               rst        - asynchronous active-high reset
//               tick_1hz   - 1 Hz count enable (1 clk wide)
//               tick_2hz   - 2 Hz adjust-increment / blink enable
//               tick_scan  - ~500 Hz digit-advance enable
//               pause_btn  - debounced single-cycle run/pause pulse
//               adj        - level, adjust mode request
//               sel        - level, adjust field (0 = minutes, 1 = seconds)
//               an         - active-low anode select, registered
//               seg        - active-low segments {g,f,e,d,c,b,a}, registered
//               running    - high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int SCAN_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_1hz,
  input  logic                   tick_2hz,
  input  logic                   tick_scan,
  input  logic                   pause_btn,
  input  logic                   adj,
  input  logic                   sel,
  output logic [SCAN_DIGITS-1:0] an,
  output logic [6:0]             seg,
  output logic                   running
);

  localparam logic [1:0] c_PAUSED = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_ADJUST = 2'd2;

  // Two-digit BCD increment; wraps to 00 after {tens_max, 9}.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] ones,
                                         input logic [3:0] tens_max);
    logic [7:0] res;
    if (ones == 4'd9) begin
      if (tens == tens_max) res = 8'h00;
      else                  res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  logic [1:0] r_state;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic [1:0] r_dig;
  logic       r_blink_ph;
  logic [SCAN_DIGITS-1:0] r_an;
  logic [6:0] r_seg;
  logic       r_running;

  logic [1:0] w_state_nxt;
  logic [7:0] w_sec_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_inc;
  logic [7:0] w_min_inc;
  logic [3:0] w_digit;
  logic [6:0] w_seg_enc;
  logic [SCAN_DIGITS-1:0] w_an_dig;
  logic       w_blank;

  // --------------------------------------------------------------------------
  // State machine: adj overrides everything; pause_btn is only honoured
  // outside ADJUST.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (adj) begin
      w_state_nxt = c_ADJUST;
    end else begin
      case (r_state)
        c_PAUSED: if (pause_btn) w_state_nxt = c_RUN;
        c_RUN:    if (pause_btn) w_state_nxt = c_PAUSED;
        default:  w_state_nxt = c_PAUSED;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counter update, decided by the current (pre-transition) state so that a
  // tick coinciding with a state change is still taken.
  // --------------------------------------------------------------------------
  assign w_sec_inc = bcd_inc(r_sec_tens, r_sec_ones, 4'd5);
  assign w_min_inc = bcd_inc(r_min_tens, r_min_ones, 4'd9);

  always_comb begin
    w_sec_nxt = {r_sec_tens, r_sec_ones};
    w_min_nxt = {r_min_tens, r_min_ones};
    if (r_state == c_RUN && tick_1hz) begin
      w_sec_nxt = w_sec_inc;
      // Carry into minutes only when seconds roll over from 59.
      if (r_sec_tens == 4'd5 && r_sec_ones == 4'd9) w_min_nxt = w_min_inc;
    end else if (r_state == c_ADJUST && tick_2hz) begin
      if (sel) w_sec_nxt = w_sec_inc;
      else     w_min_nxt = w_min_inc;
    end
  end

  // --------------------------------------------------------------------------
  // Display path
  // --------------------------------------------------------------------------
  always_comb begin
    w_digit  = r_sec_ones;
    w_an_dig = 4'b1110;
    case (r_dig)
      2'd0: begin w_digit = r_sec_ones; w_an_dig = 4'b1110; end
      2'd1: begin w_digit = r_sec_tens; w_an_dig = 4'b1101; end
      2'd2: begin w_digit = r_min_ones; w_an_dig = 4'b1011; end
      default: begin w_digit = r_min_tens; w_an_dig = 4'b0111; end
    endcase
  end

  always_comb begin
    w_seg_enc = 7'b1111111;
    case (w_digit)
      4'd0: w_seg_enc = 7'b1000000;
      4'd1: w_seg_enc = 7'b1111001;
      4'd2: w_seg_enc = 7'b0100100;
      4'd3: w_seg_enc = 7'b0110000;
      4'd4: w_seg_enc = 7'b0011001;
      4'd5: w_seg_enc = 7'b0010010;
      4'd6: w_seg_enc = 7'b0000010;
      4'd7: w_seg_enc = 7'b1111000;
      4'd8: w_seg_enc = 7'b0000000;
      4'd9: w_seg_enc = 7'b0010000;
      default: w_seg_enc = 7'b1111111;
    endcase
  end

  // Digits 0/1 are the seconds field, 2/3 the minutes field; r_dig[1]
  // distinguishes them, so the selected field is blanked when r_dig[1]
  // differs from sel.
  assign w_blank = (r_state == c_ADJUST) && r_blink_ph && (r_dig[1] != sel);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_PAUSED;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_dig      <= 2'd0;
      r_blink_ph <= 1'b0;
      r_an       <= '1;
      r_seg      <= 7'b1111111;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == c_RUN);
      r_sec_tens <= w_sec_nxt[7:4];
      r_sec_ones <= w_sec_nxt[3:0];
      r_min_tens <= w_min_nxt[7:4];
      r_min_ones <= w_min_nxt[3:0];
      if (tick_scan) r_dig      <= r_dig + 2'd1;
      if (tick_2hz)  r_blink_ph <= ~r_blink_ph;
      r_an       <= w_blank ? '1 : w_an_dig;
      r_seg      <= w_seg_enc;
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign running = r_running;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking directed bench for stopwatch_ctrl. Display
//               contents are read back by scanning all four digits and
//               comparing anode/segment patterns to hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       tick_scan = 1'b0;
  logic       pause_btn = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       running;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.SCAN_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .tick_scan (tick_scan),
    .pause_btn (pause_btn),
    .adj       (adj),
    .sel       (sel),
    .an        (an),
    .seg       (seg),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_t1();   tick_1hz  = 1'b1; cyc(); tick_1hz  = 1'b0; endtask
  task automatic pulse_t2();   tick_2hz  = 1'b1; cyc(); tick_2hz  = 1'b0; endtask
  task automatic pulse_scan(); tick_scan = 1'b1; cyc(); tick_scan = 1'b0; endtask
  task automatic pulse_pause(); pause_btn = 1'b1; cyc(); pause_btn = 1'b0; endtask

  // Scan all four digits starting from dig=0 and leave dig back at 0.
  task automatic show(input string tag, input int mt, input int mo,
                      input int st, input int so, input bit bmin, input bit bsec);
    int         dv [4];
    logic [3:0] an_exp [4];
    bit         blank;
    dv[0] = so; dv[1] = st; dv[2] = mo; dv[3] = mt;
    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101;
    an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    cyc();
    for (int d = 0; d < 4; d++) begin
      if (d > 0) begin
        pulse_scan();
        cyc();
      end
      blank = (d < 2) ? bsec : bmin;
      chk($sformatf("%s_an%0d", tag, d), {12'd0, an}, {12'd0, blank ? 4'b1111 : an_exp[d]});
      if (!blank) chk($sformatf("%s_seg%0d", tag, d), {9'd0, seg}, {9'd0, seg_of(dv[d])});
    end
    pulse_scan();
  endtask

  initial begin
    // Reset held
    repeat (3) cyc();
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {9'd0, seg}, 16'h007F);
    chk("rst_run", {15'd0, running}, 16'd0);
    rst = 1'b0;
    show("init", 0, 0, 0, 0, 0, 0);
    chk("init_run", {15'd0, running}, 16'd0);

    // Run with carry
    pulse_pause();
    chk("run_on", {15'd0, running}, 16'd1);
    repeat (59) pulse_t1();
    show("t59", 0, 0, 5, 9, 0, 0);
    pulse_t1();
    show("t60", 0, 1, 0, 0, 0, 0);

    // Full wrap with simultaneous pause
    repeat (5939) pulse_t1();
    show("t9959", 9, 9, 5, 9, 0, 0);
    tick_1hz = 1'b1; pause_btn = 1'b1;
    cyc();
    tick_1hz = 1'b0; pause_btn = 1'b0;
    chk("wrap_run", {15'd0, running}, 16'd0);
    show("wrap", 0, 0, 0, 0, 0, 0);
    repeat (3) pulse_t1();
    show("hold", 0, 0, 0, 0, 0, 0);

    // Adjust seconds, no carry into minutes
    adj = 1'b1; sel = 1'b1;
    cyc();
    repeat (58) pulse_t2();
    show("adj58", 0, 0, 5, 8, 0, 0);
    repeat (3) pulse_t2();
    show("adj01", 0, 0, 0, 1, 0, 1);
    sel = 1'b0;
    show("blkmin", 0, 0, 0, 1, 1, 0);
    pulse_t2();
    pulse_t1();
    show("adjmin", 0, 1, 0, 1, 0, 0);

    // Adjust exit, entered from RUN
    adj = 1'b0;
    cyc();
    pulse_pause();
    chk("exit_run1", {15'd0, running}, 16'd1);
    adj = 1'b1;
    cyc();
    chk("exit_adj", {15'd0, running}, 16'd0);
    adj = 1'b0;
    cyc();
    chk("exit_pau", {15'd0, running}, 16'd0);
    pulse_t1();
    show("exit_hold", 0, 1, 0, 1, 0, 0);
    pulse_pause();
    chk("exit_run2", {15'd0, running}, 16'd1);
    pulse_t1();
    show("resume", 0, 1, 0, 2, 0, 0);

    // Set 12:34, run, then asynchronous reset between edges
    adj = 1'b1; sel = 1'b0;
    cyc();
    repeat (11) pulse_t2();
    sel = 1'b1;
    repeat (32) pulse_t2();
    adj = 1'b0;
    cyc();
    pulse_pause();
    show("t1234", 1, 2, 3, 4, 0, 0);
    chk("t1234_run", {15'd0, running}, 16'd1);
    #2 rst = 1'b1;
    #2;
    chk("arst_an", {12'd0, an}, 16'h000F);
    chk("arst_seg", {9'd0, seg}, 16'h007F);
    chk("arst_run", {15'd0, running}, 16'd0);
    chk("arst_cnt", {dut.r_min_tens, dut.r_min_ones, dut.r_sec_tens, dut.r_sec_ones}, 16'h0000);
    rst = 1'b0;
    show("post", 0, 0, 0, 0, 0, 0);
    chk("post_run", {15'd0, running}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch's four-digit seven-segment display. It owns the MM:SS BCD counters and the run/pause/adjust state machine, and it time-multiplexes the digits onto the shared anode/segment bus, including adjust-mode blinking. It sits between the clock divider, which supplies the tick enables, and the board's `an`/`seg` pins. It replaces per-digit drive with a single scanned datapath.

## Interface
- `SCAN_DIGITS`, 4: number of scanned digits. Fixed; other values are unsupported.
- `clk` in 1: master clock. All logic is on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `tick_1hz` in 1: single-cycle enable, 1 Hz count tick.
- `tick_2hz` in 1: single-cycle enable, 2 Hz adjust-increment and blink tick.
- `tick_scan` in 1: single-cycle enable, about 500 Hz digit-advance tick.
- `pause_btn` in 1: debounced single-cycle pulse.
- `adj` in 1: level; adjust mode request.
- `sel` in 1: level; in adjust mode, 0 selects minutes and 1 selects seconds.
- `an` out 4: active-low anode select, registered.
- `seg` out 7: active-low segments {g,f,e,d,c,b,a}, registered.
- `running` out 1: high when the state is RUN.

## Operation
**Counters**
- `sec_ones` 0–9 and `sec_tens` 0–5, together giving seconds 00–59.
- `min_ones` 0–9 and `min_tens` 0–9, together giving minutes 00–99.
- All are 4-bit BCD. Values outside these ranges are never produced.

**State machine states:** PAUSED, RUN, ADJUST.
- PAUSED + `pause_btn` → RUN.
- RUN + `pause_btn` → PAUSED.
- Any state + `adj`=1 → ADJUST.
- ADJUST + `adj`=0 → PAUSED.
- `pause_btn` is ignored in ADJUST.
- Transitions are registered: the state changes on the clk edge that samples the event.

**RUN counting** (on `tick_1hz`)
- Seconds increment by 1.
- At 59, seconds wrap to 00 and minutes increment by 1.
- 99:59 wraps to 00:00.

**ADJUST counting** (on `tick_2hz`)
- The selected field increments by 1. The other field holds.
- Seconds wrap 59→00 with no carry into minutes. Minutes wrap 99→00.
- `tick_1hz` is ignored.

**PAUSED:** counters hold.

**Simultaneous events:** events in a given cycle are processed under the current (pre-transition) state.
- RUN with `tick_1hz` and `pause_btn` in the same cycle: the count is taken, then the state becomes PAUSED.
- RUN with `tick_1hz` and a rising `adj`: the count is taken.

**Blink**
- `blink_ph` toggles on every `tick_2hz`, in all states.
- In ADJUST with `blink_ph`=1, the two digits of the selected field are blanked (`an` bit forced to 1).
- Outside ADJUST, nothing is blanked.

**Scan**
- 2-bit index `dig` advances on `tick_scan` and wraps 3→0.
- `dig`=0: `sec_ones`, `an`=1110.
- `dig`=1: `sec_tens`, `an`=1101.
- `dig`=2: `min_ones`, `an`=1011.
- `dig`=3: `min_tens`, `an`=0111.
- Exactly one anode is low unless that digit is blanked.

**Segment encoding** ({g,f,e,d,c,b,a}, active-low)
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

## Timing
- **Reset (asynchronous):**
  - State = PAUSED; all counters = 0.
  - `dig`=0, `blink_ph`=0.
  - `an`=1111, `seg`=1111111, `running`=0.
- **Reset release:** on the first clk edge after release, `an`=1110 and `seg`=1000000.
- **Reset mid-operation** (any state, any count): all of the above values are forced immediately, with no clk needed.
- **Output latency:**
  - `an`/`seg` are registered from the current `dig`, counters, state and `blink_ph`, so they lag any change by 1 clk.
  - A counter update on `tick_1hz` appears on `seg` 1 clk later, when its digit is scanned.
- `running` is registered together with the state; it goes high on the same edge the state enters RUN.
- Ticks are assumed to be 1 clk wide. A tick held high for N cycles counts N times; this is not guarded.
- `sel` changes during ADJUST take effect for the next `tick_2hz` and the next blink evaluation.

## Test plan
- **Reset and display:** assert `rst`, release, then step `tick_scan` ×4. Required: `an` sequence 1110, 1101, 1011, 0111 with `seg`=1000000 each; `running`=0.
- **Run with carry:** `pause_btn`, then 59 `tick_1hz`. Required: 00:59. One more tick → 01:00, with `seg` for `min_ones`=1111001 when `dig`=2.
- **Full wrap and simultaneous pause:** from 99:59 in RUN, drive `tick_1hz` and `pause_btn` in the same cycle. Required: 00:00, state PAUSED, `running`=0; further ticks hold 00:00.
- **Adjust seconds:** `adj`=1, `sel`=1, from 00:58, then 3 `tick_2hz`. Required: 00:01, no minute carry; while `blink_ph`=1, `an`=1111 on `dig` 0 and 1.
- **Adjust exit:** drop `adj` while in ADJUST (entered from RUN). Required: state PAUSED, `tick_1hz` ignored, `pause_btn` resumes RUN.
- **Async reset mid-RUN at 12:34:** pulse `rst` between clk edges. Required: `an`=1111, `seg`=1111111 and counters 0 before the next edge.
